// File: rtl/adder_share_arb_if.sv
// ---------------------------------------------------------------------------
// adder_share_arb_if
// Bundle of the request, shared-adder and response signals of adder_share_arb.
//   req_valid/req_ready/req_a/req_b : N_REQ requesters, operand slice i at
//                                     [i*WIDTH +: WIDTH]
//   add_a/add_b/add_sum             : link to the external combinational adder
//   resp_valid/resp_ready/resp_sum/
//   resp_id/resp_carry              : tagged result channel
//   err                             : sticky adder self-check error
// Modports: slave = arbiter side, master = client/adder side.
// ---------------------------------------------------------------------------
interface adder_share_arb_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]       add_a;
    logic [WIDTH-1:0]       add_b;
    logic [WIDTH-1:0]       add_sum;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [WIDTH-1:0]       resp_sum;
    logic [ID_W-1:0]        resp_id;
    logic                   resp_carry;
    logic                   err;

    modport slave (
        input  req_valid, req_a, req_b, add_sum, resp_ready,
        output req_ready, add_a, add_b, resp_valid, resp_sum, resp_id,
               resp_carry, err
    );

    modport master (
        output req_valid, req_a, req_b, add_sum, resp_ready,
        input  req_ready, add_a, add_b, resp_valid, resp_sum, resp_id,
               resp_carry, err
    );
endinterface

// File: rtl/adder_share_arb.sv
// ---------------------------------------------------------------------------
// adder_share_arb
// Round-robin sequencer that time-shares one external combinational adder
// among N_REQ requesters. One operation every 3 cycles at best:
// IDLE (grant + latch operands) -> EXEC (adder driven, sum registered)
// -> RESP (held until resp_ready).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : adder_share_arb_if.slave (requests, adder link, response, err)
// Optional feature: define ADD_SELFCHECK_EN to compare add_sum against an
// internal reference adder in EXEC; a mismatch sets the sticky err flag.
// Without it err is tied 0 and no internal adder exists.
// ---------------------------------------------------------------------------
module adder_share_arb #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_share_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q;      // last granted requester
    logic [ID_W-1:0]  gid_q;      // owner of the operation in flight
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic [WIDTH-1:0] resp_sum_q;
    logic [ID_W-1:0]  resp_id_q;
    logic             resp_carry_q;
    logic             resp_valid_q;

    logic             found;
    logic [ID_W-1:0]  gnt;
    logic [N_REQ-1:0] ready_d;
    logic             accept, exec, done;

    // Round-robin search starting after ptr_q. Walking offsets from the
    // farthest to the nearest lets the nearest valid requester win.
    always_comb begin
        int idx;
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (bus.req_valid[idx]) begin
                found = 1'b1;
                gnt   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = '0;
        accept  = 1'b0;
        exec    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    accept       = 1'b1;
                    ready_d[gnt] = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                exec    = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= ID_W'(N_REQ - 1);
            gid_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            resp_sum_q   <= '0;
            resp_id_q    <= '0;
            resp_carry_q <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q <= bus.req_a[int'(gnt)*WIDTH +: WIDTH];
                op_b_q <= bus.req_b[int'(gnt)*WIDTH +: WIDTH];
                gid_q  <= gnt;
                ptr_q  <= gnt;
            end
            if (exec) begin
                resp_sum_q   <= bus.add_sum;
                // unsigned wrap detected without a wider adder
                resp_carry_q <= (bus.add_sum < op_a_q);
                resp_id_q    <= gid_q;
                resp_valid_q <= 1'b1;
            end
            if (done) resp_valid_q <= 1'b0;
        end
    end

    // Operand registers only change on accept, so the adder inputs are
    // stable through EXEC/RESP and keep their last values in IDLE.
    assign bus.add_a      = op_a_q;
    assign bus.add_b      = op_b_q;
    assign bus.req_ready  = ready_d;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_sum   = resp_sum_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_carry = resp_carry_q;

`ifdef ADD_SELFCHECK_EN
    logic [WIDTH-1:0] ref_sum;
    logic             err_q;

    assign ref_sum = op_a_q + op_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             err_q <= 1'b0;
        else if (exec && ref_sum != bus.add_sum) err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Sequencer/arbiter that time-shares one external combinational 32-bit adder (sum = a + b) among N requesters.
- Each requester issues an operand pair over valid/ready. The block grants round-robin, drives the shared adder, and registers the sum.
- The result is returned on a single response channel, tagged with the requester ID.
- Sits between the requester clients and the existing adder datapath instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/sum width; matches the adder datapath
- ID_W, 2, requester ID width; must equal clog2(N_REQ)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept strobe; one-hot or zero
- req_a  in  N_REQ*WIDTH  operand a; requester i uses slice [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand b, same packing as req_a
- add_a  out  WIDTH  operand a to the shared adder
- add_b  out  WIDTH  operand b to the shared adder
- add_sum  in  WIDTH  sum from the shared adder (combinational)
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumer ready
- resp_sum  out  WIDTH  registered sum
- resp_id  out  ID_W  index of the requester that owns resp_sum
- resp_carry  out  1  unsigned carry-out of the addition: (sum < a)
- err  out  1  sticky self-check error; tied 0 when the optional feature is absent

Behaviour:
- Reset (async, rst_n low): state=IDLE; req_ready=0; resp_valid=0; resp_sum=0; resp_id=0; resp_carry=0; err=0; add_a=add_b=0; rr pointer=N_REQ-1, so requester 0 has highest priority first.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Search req_valid starting at (ptr+1) mod N_REQ, wrapping.
  - If a requester g is found: req_ready[g]=1 combinationally this cycle (handshake completes), latch req_a/req_b slice g into operand registers, latch g, set ptr=g, go to EXEC.
  - If none is found: stay in IDLE, req_ready=0.
- EXEC:
  - add_a/add_b are driven from the operand registers. They hold these values in EXEC and RESP and keep their last values in IDLE.
  - At the clock edge: resp_sum<=add_sum, resp_carry<=(add_sum < op_a), resp_id<=g, resp_valid<=1, go to RESP.
- RESP:
  - resp_valid=1 and payload stable until resp_ready=1.
  - On resp_valid && resp_ready: resp_valid<=0, go to IDLE.
  - No new request is accepted while in EXEC or RESP; req_ready=0 there.
- Latency: accept in cycle T -> resp_valid high at T+2. Peak throughput is one operation per 3 cycles.
- Arithmetic: modulo 2^WIDTH; wrap-around is not an error and is reported only via resp_carry.
- Requester rules:
  - Payload must stay stable while req_valid is high and req_ready is low.
  - req_valid may drop before grant; a requester that drops is simply skipped.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester granted last is lowest priority in the next arbitration, which guarantees no starvation.
- resp_ready held high: RESP lasts one cycle, so back-to-back accepts are spaced exactly 3 cycles apart.
- Reset mid-operation: any in-flight operand/response is discarded and the FSM returns to IDLE with reset values. err is cleared only by reset.

Optional Feature:
- Macro ADD_SELFCHECK_EN.
- Defined:
  - In EXEC, the block computes an internal reference op_a+op_b (WIDTH bits).
  - If it differs from add_sum, err<=1 at that edge and stays set (sticky) until reset. resp_sum still carries add_sum.
- Undefined: no internal adder is built and err is constant 0.

Test Plan:
- Single request: req_valid[0]=1, a=0, b=1 -> req_ready[0] pulses one cycle; two cycles later resp_valid=1, resp_sum=1, resp_id=0, resp_carry=0.
- Carry propagation, req 2: a=0x0000FFFF, b=1 -> resp_sum=0x00010000. Then a=0x0000FFFF, b=0x0002CCC1 -> resp_sum=0x0003CCC0. Then a=0xFFFFFFFF, b=2 -> resp_sum=1, resp_carry=1.
- All 4 requesters valid continuously, resp_ready=1 -> grant order 0,1,2,3,0; accepts exactly 3 cycles apart; resp_id follows the same order.
- Backpressure: resp_ready=0 for 5 cycles while resp_valid=1 -> resp_sum/resp_id/resp_carry stable, req_ready stays 0; releasing resp_ready returns the FSM to IDLE next cycle.
- Reset mid-op: assert rst_n=0 while in EXEC -> resp_valid=0 immediately (async). After release, the first grant goes to requester 0 if it is valid.
- With ADD_SELFCHECK_EN: the bench's adder model returns sum+1 for a=1, b=2 -> resp_sum=4, err=1 and remains 1 across later correct operations until reset.
